// File: rtl/eth_rx_word_packer_if.sv
// Byte-in / word-out stream bundle between the RX MAC and the RX CDC FIFO.
// slave = packer side, master = MAC byte source plus FIFO word sink.
interface eth_rx_word_packer_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/eth_rx_word_packer.sv
// Packs RX MAC bytes little-endian into 32-bit words, pads the last word of a
// frame and appends a trailer {magic, err, 7'b0, byte_count} for the CDC FIFO.
module eth_rx_word_packer #(
  parameter logic [7:0] TRAILER_MAGIC = 8'hFE,
  parameter logic [7:0] PAD_BYTE      = 8'h00
) (
  input  logic                 aclk,
  input  logic                 areset,
  eth_rx_word_packer_if.slave  axis
);

  typedef enum logic [1:0] {
    PACK    = 2'd0,
    FLUSH   = 2'd1,
    TRAILER = 2'd2
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_acc,      w_acc_nxt;
  logic [1:0]  r_byte_idx, w_byte_idx_nxt;
  logic [15:0] r_byte_cnt, w_byte_cnt_nxt;
  logic        r_err_flag, w_err_flag_nxt;
  logic [31:0] r_tdata,    w_tdata_nxt;
  logic        r_tvalid,   w_tvalid_nxt;

  logic        w_out_free;
  logic        w_s_tready;
  logic        w_accept;
  logic [31:0] w_merged;
  logic [15:0] w_cnt_inc;

  // Lanes strictly above idx are replaced with the pad byte.
  function automatic logic [31:0] pad_word(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] res;
    res = word;
    for (int unsigned l = 0; l < 4; l++) begin
      if (l > {30'd0, idx}) res[8*l +: 8] = PAD_BYTE;
    end
    return res;
  endfunction

  assign w_out_free = !r_tvalid || axis.m_axis_tready;
  assign w_s_tready = !areset && (r_state == PACK) && ((r_byte_idx != 2'd3) || w_out_free);
  assign w_accept   = axis.s_axis_tvalid && w_s_tready;
  assign w_cnt_inc  = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;

  always_comb begin
    w_merged = r_acc;
    w_merged[8*r_byte_idx +: 8] = axis.s_axis_tdata;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_byte_idx_nxt = r_byte_idx;
    w_byte_cnt_nxt = r_byte_cnt;
    w_err_flag_nxt = r_err_flag;
    w_tdata_nxt    = r_tdata;
    w_tvalid_nxt   = r_tvalid;

    if (r_tvalid && axis.m_axis_tready) w_tvalid_nxt = 1'b0;

    unique case (r_state)
      PACK: begin
        if (w_accept) begin
          w_acc_nxt      = w_merged;
          w_byte_cnt_nxt = w_cnt_inc;
          w_err_flag_nxt = r_err_flag | axis.s_axis_tuser;
          if (axis.s_axis_tlast) begin
            if (w_out_free) begin
              w_tdata_nxt  = pad_word(w_merged, r_byte_idx);
              w_tvalid_nxt = 1'b1;
              w_state_nxt  = TRAILER;
            end else begin
              // Byte index is kept so FLUSH pads above the frame's last lane.
              w_state_nxt  = FLUSH;
            end
          end else if (r_byte_idx == 2'd3) begin
            w_tdata_nxt    = w_merged;
            w_tvalid_nxt   = 1'b1;
            w_byte_idx_nxt = 2'd0;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_tdata_nxt  = pad_word(r_acc, r_byte_idx);
          w_tvalid_nxt = 1'b1;
          w_state_nxt  = TRAILER;
        end
      end
      TRAILER: begin
        if (w_out_free) begin
          w_tdata_nxt    = {TRAILER_MAGIC, r_err_flag, 7'b0, r_byte_cnt};
          w_tvalid_nxt   = 1'b1;
          w_acc_nxt      = '0;
          w_byte_idx_nxt = '0;
          w_byte_cnt_nxt = '0;
          w_err_flag_nxt = 1'b0;
          w_state_nxt    = PACK;
        end
      end
      default: w_state_nxt = PACK;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= PACK;
      r_acc      <= '0;
      r_byte_idx <= '0;
      r_byte_cnt <= '0;
      r_err_flag <= 1'b0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_tdata    <= w_tdata_nxt;
      r_tvalid   <= w_tvalid_nxt;
    end
  end

  assign axis.s_axis_tready = w_s_tready;
  assign axis.m_axis_tdata  = r_tdata;
  assign axis.m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Directed bench for eth_rx_word_packer: expected words are queued per frame
// and checked by a monitor as the downstream side accepts them.
module tb_eth_rx_word_packer;
  logic aclk;
  logic areset;
  int   n_cmp;
  int   n_fail;
  logic [31:0] exp_q[$];

  eth_rx_word_packer_if bus ();

  eth_rx_word_packer #(
    .TRAILER_MAGIC (8'hFE),
    .PAD_BYTE      (8'h00)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are stable from negedge to the next posedge, so a handshake seen
  // here is the one that completes at the coming edge.
  always @(negedge aclk) begin
    if (!areset && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("out_word", bus.m_axis_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    bit done;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    bus.s_axis_tuser  = user;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      if (bus.s_axis_tready === 1'b1) done = 1'b1;
      @(posedge aclk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge aclk);
    #1;
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    areset = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b1;
    idle_in();

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
    chk("rst_m_tdata", bus.m_axis_tdata, 32'd0);
    chk("rst_s_tready_after", {31'd0, bus.s_axis_tready}, 32'd1);
    @(posedge aclk); #1;

    // 1: 8-byte frame ending on lane 3
    exp_q.push_back(32'h04030201); exp_q.push_back(32'h08070605); exp_q.push_back(32'hFE000008);
    for (int b = 1; b <= 8; b++) send_byte(8'(b), b == 8, 1'b0);

    // 2: 5-byte frame, back-to-back
    exp_q.push_back(32'h14131211); exp_q.push_back(32'h00000015); exp_q.push_back(32'hFE000005);
    for (int b = 0; b < 5; b++) send_byte(8'h11 + 8'(b), b == 4, 1'b0);

    // 3: 1-byte frame with error
    exp_q.push_back(32'h000000AA); exp_q.push_back(32'hFE800001);
    send_byte(8'hAA, 1'b1, 1'b1);
    idle_in();
    drain();

    // 4: downstream stall after the first word
    exp_q.push_back(32'h04030201); exp_q.push_back(32'h08070605); exp_q.push_back(32'hFE000008);
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b0, 1'b0);
    bus.m_axis_tready = 1'b0;
    for (int b = 5; b <= 7; b++) send_byte(8'(b), 1'b0, 1'b0);
    bus.s_axis_tdata = 8'h08;
    bus.s_axis_tlast = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge aclk);
      chk("stall_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
      chk("stall_m_tdata", bus.m_axis_tdata, 32'h04030201);
    end
    @(posedge aclk); #1;
    bus.m_axis_tready = 1'b1;
    send_byte(8'h08, 1'b1, 1'b0);

    // 5: trailer held downstream while the next short frame ends -> FLUSH
    exp_q.push_back(32'h00CCBBAA); exp_q.push_back(32'hFE000003);
    exp_q.push_back(32'h04030201); exp_q.push_back(32'hFE000004);
    bus.s_axis_tdata = 8'hAA;
    bus.s_axis_tlast = 1'b0;
    @(posedge aclk); #1;
    bus.m_axis_tready = 1'b0;
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b1, 1'b0);
    bus.s_axis_tdata = 8'h01;
    bus.s_axis_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("flush_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
      chk("flush_hold_trailer", bus.m_axis_tdata, 32'hFE000008);
      @(posedge aclk); #1;
    end
    bus.m_axis_tready = 1'b1;
    @(negedge aclk);
    chk("flush_release_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("trailer_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    @(posedge aclk); #1;
    for (int b = 1; b <= 4; b++) send_byte(8'(b), b == 4, 1'b0);
    idle_in();
    drain();

    // 6: reset mid-frame with a pending word discards everything
    bus.m_axis_tready = 1'b0;
    for (int b = 0; b < 6; b++) send_byte(8'h41 + 8'(b), 1'b0, 1'b0);
    idle_in();
    @(negedge aclk);
    chk("pending_word_before_reset", bus.m_axis_tdata, 32'h44434241);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst_s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("post_rst_m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
    end
    @(posedge aclk); #1;
    exp_q.push_back(32'h24232221); exp_q.push_back(32'hFE000004);
    for (int b = 0; b < 4; b++) send_byte(8'h21 + 8'(b), b == 3, 1'b0);
    idle_in();
    drain();
    repeat (3) @(posedge aclk);
    #1;
    chk("end_m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
